// File: rtl/satd_hadamard_accum.sv
// SATD engine: per-row 8-point Hadamard of ORG-CUR differences, |H| summed and accumulated over BEATS rows.
// Optional SATD_ROUND_EN: block result is halved with round-half-up inside the output register.
module satd_hadamard_accum #(
  parameter int BEATS = 16,
  parameter int ACC_W = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [63:0]              org_row,
  input  logic [63:0]              cur_row,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         satd_out,
  output logic [$clog2(BEATS)-1:0] beat_idx
);
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [BW-1:0]     beat_q, beat_d;
  logic [4:0]        vld_q, vld_d;
  logic [4:0]        lst_q, lst_d;
  logic signed [8:0]  s1_q [8];
  logic signed [8:0]  s1_d [8];
  logic signed [9:0]  s2_q [8];
  logic signed [9:0]  s2_d [8];
  logic signed [10:0] s3_q [8];
  logic signed [10:0] s3_d [8];
  logic signed [11:0] s4_q [8];
  logic signed [11:0] s4_d [8];
  logic [10:0]       hmag [8];
  logic [13:0]       rs_q, rs_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [ACC_W-1:0]  satd_q, satd_d, satd_final;
  logic              ov_q, ov_d;

  // Butterflies: lower lane takes the sum, upper lane takes lower minus upper.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign s1_d[i] = $signed({1'b0, org_row[8*i +: 8]}) - $signed({1'b0, cur_row[8*i +: 8]});
    if ((i & 1) == 0) begin : g_s2_lo
      assign s2_d[i] = 10'(s1_q[i]) + 10'(s1_q[i+1]);
    end else begin : g_s2_hi
      assign s2_d[i] = 10'(s1_q[i-1]) - 10'(s1_q[i]);
    end
    if ((i & 2) == 0) begin : g_s3_lo
      assign s3_d[i] = 11'(s2_q[i]) + 11'(s2_q[i+2]);
    end else begin : g_s3_hi
      assign s3_d[i] = 11'(s2_q[i-2]) - 11'(s2_q[i]);
    end
    if ((i & 4) == 0) begin : g_s4_lo
      assign s4_d[i] = 12'(s3_q[i]) + 12'(s3_q[i+4]);
    end else begin : g_s4_hi
      assign s4_d[i] = 12'(s3_q[i-4]) - 12'(s3_q[i]);
    end
    assign hmag[i] = s4_q[i][11] ? 11'(-s4_q[i]) : 11'(s4_q[i]);
  end

  assign rs_d = 14'(hmag[0]) + 14'(hmag[1]) + 14'(hmag[2]) + 14'(hmag[3])
              + 14'(hmag[4]) + 14'(hmag[5]) + 14'(hmag[6]) + 14'(hmag[7]);

  assign acc_sum = acc_q + ACC_W'(rs_q);

`ifdef SATD_ROUND_EN
  logic [ACC_W:0] acc_rnd;
  assign acc_rnd    = {1'b0, acc_sum} + {{ACC_W{1'b0}}, 1'b1};
  assign satd_final = acc_rnd[ACC_W:1];
`else
  assign satd_final = acc_sum;
`endif

  // Beat counter and valid/last tags that ride alongside the data stages.
  always_comb begin
    beat_d = beat_q;
    if (in_valid) begin
      beat_d = beat_q + BW'(1);
    end else begin
      beat_d = beat_q;
    end
    vld_d = {vld_q[3:0], in_valid};
    lst_d = {lst_q[3:0], in_valid && (beat_q == LAST_BEAT)};
  end

  // Accumulate stage: a last row publishes the block total and restarts the accumulator at zero.
  always_comb begin
    acc_d  = acc_q;
    satd_d = satd_q;
    ov_d   = 1'b0;
    if (vld_q[4]) begin
      if (lst_q[4]) begin
        acc_d  = '0;
        satd_d = satd_final;
        ov_d   = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Control and output registers; reset drops any partial block and in-flight rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      vld_q  <= '0;
      lst_q  <= '0;
      acc_q  <= '0;
      satd_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      beat_q <= beat_d;
      vld_q  <= vld_d;
      lst_q  <= lst_d;
      acc_q  <= acc_d;
      satd_q <= satd_d;
      ov_q   <= ov_d;
    end
  end

  // Datapath registers are qualified by the valid tags, so they need no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    s3_q <= s3_d;
    s4_q <= s4_d;
    rs_q <= rs_d;
  end

  assign out_valid = ov_q;
  assign satd_out  = satd_q;
  assign beat_idx  = beat_q;

endmodule

// File: tb/tb_satd_hadamard_accum.sv
// Scoreboard bench for satd_hadamard_accum: driver pushes expected block results, a negedge monitor checks them.
module tb_satd_hadamard_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] org;
  logic [63:0] cur;
  logic        out_valid;
  logic [17:0] satd_out;
  logic [3:0]  beat_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_val_q[$];
  int exp_cyc_q[$];
  int mon_v;
  int mon_c;

  localparam logic [63:0] ALT_ORG = 64'h0001_0001_0001_0001;
  localparam logic [63:0] ALT_CUR = 64'h0100_0100_0100_0100;
  localparam logic [63:0] TEN     = 64'h0A0A_0A0A_0A0A_0A0A;
  localparam logic [63:0] MID     = 64'h8080_8080_8080_8080;
  localparam logic [63:0] FIFTY5  = 64'h5555_5555_5555_5555;

  satd_hadamard_accum #(.BEATS(16), .ACC_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .org_row   (org),
    .cur_row   (cur),
    .out_valid (out_valid),
    .satd_out  (satd_out),
    .beat_idx  (beat_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_of(input int raw);
`ifdef SATD_ROUND_EN
    return (raw + 1) / 2;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] o, input logic [63:0] c);
    @(negedge clk);
    in_valid = v;
    org      = o;
    cur      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 64'd0, 64'd0);
  endtask

  task automatic run_block(input logic [63:0] of, input logic [63:0] cf,
                           input logic [63:0] orr, input logic [63:0] cr,
                           input bit bubbles, input int raw);
    for (int k = 0; k < 16; k++) begin
      if (bubbles) idle(int'($urandom_range(0, 2)));
      if (k == 0) drive(1'b1, of, cf);
      else        drive(1'b1, orr, cr);
    end
    exp_val_q.push_back(exp_of(raw));
    exp_cyc_q.push_back(cyc + 5);
  endtask

  // Monitor: every out_valid pulse must match the head of the scoreboard in value and cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_val_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got satd_out=%0d at cycle %0d, expected no pulse", satd_out, cyc);
      end else begin
        mon_v = exp_val_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("pulse_value", int'(satd_out), mon_v);
        check("pulse_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    org      = 64'd0;
    cur      = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_satd_out", int'(satd_out), 0);
    check("reset_beat_idx", int'(beat_idx), 0);
    rst = 1'b0;

    run_block(MID, MID, MID, MID, 1'b0, 0);
    idle(8);
    run_block(TEN, 64'd0, TEN, 64'd0, 1'b0, 1280);
    idle(8);
    check("hold_after_block", int'(satd_out), exp_of(1280));
    run_block(64'd0, 64'h0000_0000_0000_00FF, FIFTY5, FIFTY5, 1'b0, 2040);
    idle(8);
    run_block(ALT_ORG, ALT_CUR, ALT_ORG, ALT_CUR, 1'b0, 128);
    idle(8);
    run_block(ALT_ORG, ALT_CUR, ALT_ORG, ALT_CUR, 1'b1, 128);
    idle(8);

    run_block(TEN, 64'd0, TEN, 64'd0, 1'b0, 1280);
    run_block(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 0);
    idle(8);

    for (int k = 0; k < 7; k++) drive(1'b1, TEN, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("beat_idx_mid_block", int'(beat_idx), 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("beat_idx_after_reset", int'(beat_idx), 0);
    check("out_valid_after_reset", int'(out_valid), 0);
    rst = 1'b0;
    run_block(64'd0, 64'h0000_0000_0000_00FF, FIFTY5, FIFTY5, 1'b0, 2040);
    idle(2);

    for (int w = 0; w < 40 && exp_val_q.size() != 0; w++) @(posedge clk);
    check("scoreboard_drained", exp_val_q.size(), 0);
    idle(4);
    check("final_hold", int'(satd_out), exp_of(2040));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/satd_hadamard_accum.md
Name: satd_hadamard_accum

Overview:
- Downstream consumer of the ORG/CUR shift register stage.
- Each beat takes one 8-sample row of original (ORG) and current (CUR) pixels and forms the difference row.
- Applies an 8-point 1-D Hadamard transform to the difference row, then sums the absolute values of the coefficients.
- Accumulates that row sum over BEATS rows (default 16 rows = one 128-sample block) and emits one SATD value per block.

Parameters:
- BEATS, 16, rows per block; power of two, 2..64.
- ACC_W, 18, width of accumulator and satd_out; must hold BEATS*16320.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  row on org_row/cur_row is valid this cycle.
- org_row  in  64  8 unsigned bytes; lane i = org_row[8*i+7:8*i].
- cur_row  in  64  8 unsigned bytes; same lane mapping.
- out_valid  out  1  one-cycle pulse, satd_out valid.
- satd_out  out  ACC_W  block SATD, unsigned.
- beat_idx  out  log2(BEATS)  index of the next row to be accepted within the current block.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, satd_out=0, beat_idx=0. All pipeline valid bits=0. Accumulator=0.
- Reset mid-block discards the partial block and any in-flight rows. No out_valid pulse is produced for a discarded block.
- Flow control: no backpressure. Every cycle with in_valid=1 accepts a row. Bubbles (in_valid=0) are allowed anywhere, including inside a block.
- Beat counter: increments on each accepted row and wraps from BEATS-1 to 0. The row accepted at beat_idx==BEATS-1 is tagged "last". The tag travels with that row through the pipeline.
- S1: d[i] = org[i] - cur[i], 9-bit signed, range -255..255. Registered.
- S2..S4: three butterfly stages, each registered. Stage s pairs lanes j and j+2^(s-2): sum goes to the lower lane, difference (lower minus upper) to the upper lane. Width grows one bit per stage; 12-bit signed after S4.
- Transform result: H[k] = sum_j (-1)^popcount(j&k) * d[j], natural Sylvester order.
- S5: |H[k]| as 11-bit unsigned. Adder tree of 8 values gives a 14-bit row sum. Registered.
- S6 (accumulate):
  - Non-last row: acc <= acc + rowsum.
  - Last row: satd_out <= acc + rowsum, out_valid <= 1, acc <= 0.
  - Bubble: acc unchanged.
- Latency: last row accepted at clock edge E → out_valid high in the cycle after edge E+5, i.e. 6 registers from input to output.
- out_valid is 1 for exactly one cycle per block. satd_out holds its value until the next block completes.
- Back-to-back blocks with no gaps are supported. The first row of block n+1 may enter S6 in the same cycle that block n's last row is accumulated. acc restarts from 0 plus that row's sum, with no loss.
- Overflow cannot occur for legal ACC_W. No saturation logic is required.

Optional Feature:
- Macro: SATD_ROUND_EN.
- Defined: satd_out = (acc_final + 1) >> 1, i.e. the conventional halved SATD with round-half-up. The MSB of satd_out is then always 0. Latency is unchanged; the rounding is folded into the S6 register.
- Undefined: satd_out = raw acc_final.

Test Plan:
- 16 consecutive rows, org=cur=0x80 in all lanes → out_valid 6 cycles after the last row; satd_out=0.
- 16 rows, org lanes all 10, cur lanes all 0 → each row H0=80, other coefficients 0; satd_out=1280 (640 with SATD_ROUND_EN).
- One row with lane 0 org=0, cur=255; the other 15 rows equal → row sum 8*255; satd_out=2040 (1020 rounded).
- 16 rows, d alternating +1/-1 across lanes (org=1/0, cur=0/1) → only H1=8; satd_out=128. Repeat with random in_valid bubbles → same result, out_valid 6 cycles after the 16th accepted row.
- Two blocks back to back: block A from test 2, block B all zeros → two pulses 16 cycles apart; values 1280 then 0, with no carry-over between blocks.
- Assert rst after 7 rows of block A, then feed a full block B (test 3 data) → no pulse for A; beat_idx=0 right after reset; single pulse with 2040.
